// File: rtl/tinyrv1_mem_pkg.sv
// Shared request/response types and parameter sanity helpers for the TinyRV1 test memory.
package tinyrv1_mem_pkg;

  localparam logic MEM_REQ_READ  = 1'b0;
  localparam logic MEM_REQ_WRITE = 1'b1;

  typedef struct packed {
    logic        err;
    logic [31:0] data;
  } mem_resp_t;

  function automatic bit isPow2(input int unsigned value);
    return (value != 0) && ((value & (value - 1)) == 0);
  endfunction

  function automatic bit latencyLegal(input int unsigned latency);
    return (latency >= 1) && (latency <= 4);
  endfunction

  function automatic bit depthLegal(input int unsigned latency, input int unsigned depth);
    return depth >= latency + 1;
  endfunction

  function automatic bit paramsLegal(input int unsigned numWords, input int unsigned latency,
                                     input int unsigned depth);
    return isPow2(numWords) && (numWords >= 2) && latencyLegal(latency) &&
           depthLegal(latency, depth);
  endfunction

endpackage

// File: rtl/mem_resp_queue.sv
// Per-port response path: a LATENCY-stage capture pipe feeding an in-order response FIFO,
// with a credit counter that throttles request acceptance so the FIFO can never overflow.
module mem_resp_queue
  import tinyrv1_mem_pkg::*;
#(
  parameter int unsigned LATENCY     = 1,
  parameter int unsigned QUEUE_DEPTH = 2
) (
  input  logic      clk,
  input  logic      rst,
  input  logic      req_fire_i,
  input  mem_resp_t req_resp_i,
  output logic      req_rdy_o,
  output logic      resp_val_o,
  input  logic      resp_rdy_i,
  output mem_resp_t resp_o
);

  localparam int unsigned CW = $clog2(QUEUE_DEPTH + 1);
  localparam int unsigned PW = (QUEUE_DEPTH > 1) ? $clog2(QUEUE_DEPTH) : 1;

  logic [LATENCY-1:0] pipeValid_q;
  mem_resp_t          pipeData_q [LATENCY];
  mem_resp_t          fifo_q [QUEUE_DEPTH];
  logic [PW-1:0]      head_q, head_d, tail_q, tail_d;
  logic [CW-1:0]      count_q, count_d, outstanding_q, outstanding_d;
  logic               push, pop;

  function automatic logic [PW-1:0] nextPtr(input logic [PW-1:0] ptr);
    return (ptr == PW'(QUEUE_DEPTH - 1)) ? '0 : ptr + PW'(1);
  endfunction

  assign push       = pipeValid_q[LATENCY-1];
  assign resp_val_o = (count_q != '0);
  assign pop        = resp_val_o & resp_rdy_i;
  assign resp_o     = resp_val_o ? fifo_q[head_q] : '0;
  assign req_rdy_o  = (outstanding_q < CW'(QUEUE_DEPTH));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pipeValid_q <= '0;
    end else begin
      pipeValid_q[0] <= req_fire_i;
      for (int i = 1; i < LATENCY; i++) pipeValid_q[i] <= pipeValid_q[i-1];
    end
  end

  // Payload storage needs no reset; only the valid tags and counters define occupancy.
  always_ff @(posedge clk) begin
    pipeData_q[0] <= req_resp_i;
    for (int i = 1; i < LATENCY; i++) pipeData_q[i] <= pipeData_q[i-1];
    if (push) fifo_q[tail_q] <= pipeData_q[LATENCY-1];
  end

  always_comb begin
    head_d        = pop  ? nextPtr(head_q) : head_q;
    tail_d        = push ? nextPtr(tail_q) : tail_q;
    count_d       = count_q;
    outstanding_d = outstanding_q;
    if (push && !pop)      count_d = count_q + CW'(1);
    else if (!push && pop) count_d = count_q - CW'(1);
    if (req_fire_i && !pop)      outstanding_d = outstanding_q + CW'(1);
    else if (!req_fire_i && pop) outstanding_d = outstanding_q - CW'(1);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      head_q        <= '0;
      tail_q        <= '0;
      count_q       <= '0;
      outstanding_q <= '0;
    end else begin
      head_q        <= head_d;
      tail_q        <= tail_d;
      count_q       <= count_d;
      outstanding_q <= outstanding_d;
    end
  end

endmodule

// File: rtl/tinyrv1_mem_responder.sv
// TinyRV1 test memory: one word array shared by an instruction-fetch port and a load/store
// port, each with its own latency pipe and credit-limited response queue.
module tinyrv1_mem_responder
  import tinyrv1_mem_pkg::*;
#(
  parameter int unsigned NUM_WORDS   = 256,
  parameter int unsigned LATENCY     = 1,
  parameter int unsigned QUEUE_DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        imemreq_val,
  output logic        imemreq_rdy,
  input  logic [31:0] imemreq_addr,
  output logic        imemresp_val,
  input  logic        imemresp_rdy,
  output logic [31:0] imemresp_data,
  output logic        imemresp_err,
  input  logic        dmemreq_val,
  output logic        dmemreq_rdy,
  input  logic        dmemreq_type,
  input  logic [31:0] dmemreq_addr,
  input  logic [31:0] dmemreq_wdata,
  output logic        dmemresp_val,
  input  logic        dmemresp_rdy,
  output logic [31:0] dmemresp_data,
  output logic        dmemresp_err,
  input  logic        init_wen,
  input  logic [31:0] init_addr,
  input  logic [31:0] init_wdata
);

  localparam int unsigned AW = $clog2(NUM_WORDS);

  logic [31:0]   mem [NUM_WORDS];
  logic [AW-1:0] imemIdx, dmemIdx, initIdx;
  logic          imemMisaligned, dmemMisaligned;
  logic          imemFire, dmemFire, dmemWrite;
  mem_resp_t     imemCapture, dmemCapture, imemResp, dmemResp;
  logic          unusedAddrBits;

  assign imemIdx        = imemreq_addr[2 +: AW];
  assign dmemIdx        = dmemreq_addr[2 +: AW];
  assign initIdx        = init_addr[2 +: AW];
  assign imemMisaligned = |imemreq_addr[1:0];
  assign dmemMisaligned = |dmemreq_addr[1:0];
  assign unusedAddrBits = ^{imemreq_addr[31:AW+2], dmemreq_addr[31:AW+2],
                            init_addr[31:AW+2], init_addr[1:0]};

  assign imemFire  = imemreq_val & imemreq_rdy;
  assign dmemFire  = dmemreq_val & dmemreq_rdy;
  assign dmemWrite = dmemFire & (dmemreq_type == MEM_REQ_WRITE) & ~dmemMisaligned;

  // Reads see the array before this edge's writes, so a same-cycle store is invisible to fetch.
  always_comb begin
    imemCapture.err  = imemMisaligned;
    imemCapture.data = imemMisaligned ? '0 : mem[imemIdx];
    dmemCapture.err  = dmemMisaligned;
    dmemCapture.data = (dmemMisaligned || dmemreq_type != MEM_REQ_READ) ? '0 : mem[dmemIdx];
  end

  // The later assignment wins, giving the processor's store priority over a preload.
  always_ff @(posedge clk) begin
    if (init_wen)  mem[initIdx] <= init_wdata;
    if (dmemWrite) mem[dmemIdx] <= dmemreq_wdata;
  end

  if (paramsLegal(NUM_WORDS, LATENCY, QUEUE_DEPTH)) begin : g_ports
    mem_resp_queue #(
      .LATENCY     (LATENCY),
      .QUEUE_DEPTH (QUEUE_DEPTH)
    ) imemQueue (
      .clk        (clk),
      .rst        (rst),
      .req_fire_i (imemFire),
      .req_resp_i (imemCapture),
      .req_rdy_o  (imemreq_rdy),
      .resp_val_o (imemresp_val),
      .resp_rdy_i (imemresp_rdy),
      .resp_o     (imemResp)
    );

    mem_resp_queue #(
      .LATENCY     (LATENCY),
      .QUEUE_DEPTH (QUEUE_DEPTH)
    ) dmemQueue (
      .clk        (clk),
      .rst        (rst),
      .req_fire_i (dmemFire),
      .req_resp_i (dmemCapture),
      .req_rdy_o  (dmemreq_rdy),
      .resp_val_o (dmemresp_val),
      .resp_rdy_i (dmemresp_rdy),
      .resp_o     (dmemResp)
    );
  end else begin : g_illegal
    // An unusable configuration yields a memory that never accepts, which stalls a bench visibly.
    assign imemreq_rdy  = 1'b0;
    assign dmemreq_rdy  = 1'b0;
    assign imemresp_val = 1'b0;
    assign dmemresp_val = 1'b0;
    assign imemResp     = '0;
    assign dmemResp     = '0;
  end

  assign imemresp_data = imemResp.data;
  assign imemresp_err  = imemResp.err;
  assign dmemresp_data = dmemResp.data;
  assign dmemresp_err  = dmemResp.err;

endmodule
